// File: rtl/act_mem_pkg.sv
// Shared definitions for the activation memory controller.
package act_mem_pkg;

    // Width of every index port towards the activation memory.
    localparam int INDEX_W = 16;

    // Controller operating states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Register width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/act_index_counter.sv
// Raster-order (entry, y, x) element counter: x runs fastest, entry slowest.
// Indices are presented zero-extended to INDEX_W bits.
module act_index_counter
    import act_mem_pkg::*;
#(
    parameter int ENTRY_NUM = 1,
    parameter int DIM       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [INDEX_W-1:0] entry,
    output logic [INDEX_W-1:0] y,
    output logic [INDEX_W-1:0] x,
    output logic               last
);

    localparam int EW = cnt_width(ENTRY_NUM);
    localparam int DW = cnt_width(DIM);

    localparam logic [EW-1:0] ENTRY_MAX = EW'(ENTRY_NUM - 1);
    localparam logic [DW-1:0] DIM_MAX   = DW'(DIM - 1);

    logic [EW-1:0] entry_reg, entry_next;
    logic [DW-1:0] y_reg, y_next;
    logic [DW-1:0] x_reg, x_next;

    logic x_at_max, y_at_max, entry_at_max;

    assign x_at_max     = (x_reg == DIM_MAX);
    assign y_at_max     = (y_reg == DIM_MAX);
    assign entry_at_max = (entry_reg == ENTRY_MAX);

    // Next-count logic: clear wins; the final element wraps everything to 0.
    always_comb begin
        entry_next = entry_reg;
        y_next     = y_reg;
        x_next     = x_reg;
        if (clear) begin
            entry_next = '0;
            y_next     = '0;
            x_next     = '0;
        end else if (advance) begin
            if (x_at_max) begin
                x_next = '0;
                if (y_at_max) begin
                    y_next     = '0;
                    entry_next = entry_at_max ? '0 : entry_reg + 1'b1;
                end else begin
                    y_next = y_reg + 1'b1;
                end
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_reg <= '0;
            y_reg     <= '0;
            x_reg     <= '0;
        end else begin
            entry_reg <= entry_next;
            y_reg     <= y_next;
            x_reg     <= x_next;
        end
    end

    assign entry = INDEX_W'(entry_reg);
    assign y     = INDEX_W'(y_reg);
    assign x     = INDEX_W'(x_reg);
    assign last  = x_at_max && y_at_max && entry_at_max;

endmodule

// File: rtl/act_mem_ctrl.sv
// Activation memory controller: fills the memory from an inbound stream
// (LOAD) or streams its contents out (DUMP), one element per cycle.
module act_mem_ctrl
    import act_mem_pkg::*;
#(
    parameter int ENTRY_NUM = 1,
    parameter int DIM       = 1,
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_load,
    input  logic                 start_dump,
    output logic                 busy,
    output logic                 done,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_SIZE-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 mem_write,
    output logic [DATA_SIZE-1:0] mem_in_data,
    output logic [INDEX_W-1:0]   mem_index_entry,
    output logic [INDEX_W-1:0]   mem_index_y,
    output logic [INDEX_W-1:0]   mem_index_x,
    output logic [INDEX_W-1:0]   mem_read_index_entry,
    output logic [INDEX_W-1:0]   mem_read_index_y,
    output logic [INDEX_W-1:0]   mem_read_index_x,
    input  logic [DATA_SIZE-1:0] mem_out_data
);

    state_t state_reg, state_next;

    logic               in_load, in_dump;
    logic               cnt_clear, cnt_advance, cnt_last;
    logic [INDEX_W-1:0] cnt_entry, cnt_y, cnt_x;

    assign in_load = (state_reg == ST_LOAD);
    assign in_dump = (state_reg == ST_DUMP);

    // Counter sits at zero while idle so every operation starts at (0,0,0).
    assign cnt_clear   = (state_reg == ST_IDLE);
    assign cnt_advance = (in_load && s_valid) || (in_dump && m_ready);

    act_index_counter #(
        .ENTRY_NUM (ENTRY_NUM),
        .DIM       (DIM)
    ) u_index_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .entry   (cnt_entry),
        .y       (cnt_y),
        .x       (cnt_x),
        .last    (cnt_last)
    );

    // Next-state logic; start requests only matter in IDLE, load has priority.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_load) begin
                    state_next = ST_LOAD;
                end else if (start_dump) begin
                    state_next = ST_DUMP;
                end
            end
            ST_LOAD: begin
                if (s_valid && cnt_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DUMP: begin
                if (m_ready && cnt_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign busy = in_load || in_dump;
    assign done = (state_reg == ST_DONE);

    // Inbound stream: always ready during LOAD, so every valid beat is a write.
    assign s_ready     = in_load;
    assign mem_write   = in_load && s_valid;
    assign mem_in_data = s_data;

    // Outbound stream: memory read is combinational, so data follows the index.
    assign m_valid = in_dump;
    assign m_data  = mem_out_data;

    // Index ports are only live in the state that uses them, zero otherwise.
    assign mem_index_entry      = in_load ? cnt_entry : '0;
    assign mem_index_y          = in_load ? cnt_y     : '0;
    assign mem_index_x          = in_load ? cnt_x     : '0;
    assign mem_read_index_entry = in_dump ? cnt_entry : '0;
    assign mem_read_index_y     = in_dump ? cnt_y     : '0;
    assign mem_read_index_x     = in_dump ? cnt_x     : '0;

endmodule

// File: tb/tb_act_mem_ctrl.sv
// Scoreboard bench for act_mem_ctrl (2 entries of 2x2, plus a 1x1x1 instance).
module tb_act_mem_ctrl;

    localparam int EN = 2;
    localparam int DM = 2;
    localparam int N  = EN * DM * DM;

    typedef struct {
        logic [47:0] idx;
        logic [63:0] d;
        bit          last;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load, start_dump, s_valid, m_ready;
    logic [63:0] s_data;
    logic        busy, done, s_ready, m_valid, mem_write;
    logic [63:0] m_data, mem_in_data, mem_out_data;
    logic [15:0] wi_e, wi_y, wi_x, ri_e, ri_y, ri_x;

    logic        b_start_load, b_start_dump, b_s_valid, b_m_ready;
    logic [63:0] b_s_data;
    logic        b_busy, b_done, b_s_ready, b_m_valid, b_mem_write;
    logic [63:0] b_m_data, b_mem_in_data;
    logic [15:0] b_wi_e, b_wi_y, b_wi_x, b_ri_e, b_ri_y, b_ri_x;

    logic [63:0] mem_a [0:N-1];
    logic [63:0] b_mem;
    logic [63:0] ref_mem [0:N-1];

    item_t wr_q[$];
    item_t rd_q[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    act_mem_ctrl #(.ENTRY_NUM(EN), .DIM(DM), .DATA_SIZE(64)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_dump(start_dump),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .mem_write(mem_write), .mem_in_data(mem_in_data),
        .mem_index_entry(wi_e), .mem_index_y(wi_y), .mem_index_x(wi_x),
        .mem_read_index_entry(ri_e), .mem_read_index_y(ri_y), .mem_read_index_x(ri_x),
        .mem_out_data(mem_out_data)
    );

    act_mem_ctrl #(.ENTRY_NUM(1), .DIM(1), .DATA_SIZE(64)) dut_b (
        .clk(clk), .rst(rst), .start_load(b_start_load), .start_dump(b_start_dump),
        .busy(b_busy), .done(b_done),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .mem_write(b_mem_write), .mem_in_data(b_mem_in_data),
        .mem_index_entry(b_wi_e), .mem_index_y(b_wi_y), .mem_index_x(b_wi_x),
        .mem_read_index_entry(b_ri_e), .mem_read_index_y(b_ri_y), .mem_read_index_x(b_ri_x),
        .mem_out_data(b_mem)
    );

    // Activation memory models: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_write) mem_a[{wi_e[0], wi_y[0], wi_x[0]}] <= mem_in_data;
        if (b_mem_write) b_mem <= b_mem_in_data;
    end
    assign mem_out_data = mem_a[{ri_e[0], ri_y[0], ri_x[0]}];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Element k in raster order -> {entry, y, x}
    function automatic logic [47:0] idx_of(input int k);
        return {16'(k / (DM * DM)), 16'((k / DM) % DM), 16'(k % DM)};
    endfunction

    // Monitor: pops expected writes/reads as the DUT presents them.
    initial begin : monitor
        item_t       it;
        bit          hold_valid = 0;
        logic [63:0] hold_data  = '0;
        int          done_stage = 0;
        bit          fire_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_valid = 0;
                done_stage = 0;
            end else begin
                fire_done = 0;
                if (done_stage == 1) begin
                    chk(done && !busy, "done_pulse", {62'd0, done, busy}, 64'd2);
                    done_stage = 2;
                end else if (done_stage == 2) begin
                    chk(!done, "done_width", {63'd0, done}, 64'd0);
                    done_stage = 0;
                end else if (done) begin
                    chk(1'b0, "done_spurious", 64'd1, 64'd0);
                end
                if (s_ready && !s_valid)
                    chk(!mem_write, "wr_gate", {63'd0, mem_write}, 64'd0);
                if (mem_write) begin
                    if (wr_q.size() == 0) begin
                        chk(1'b0, "wr_unexpected", mem_in_data, 64'd0);
                    end else begin
                        it = wr_q.pop_front();
                        chk({wi_e, wi_y, wi_x} == it.idx, "wr_index", {16'd0, wi_e, wi_y, wi_x}, {16'd0, it.idx});
                        chk(mem_in_data == it.d, "wr_data", mem_in_data, it.d);
                        if (it.last) fire_done = 1;
                    end
                end
                if (hold_valid && m_valid)
                    chk(m_data == hold_data, "rd_stable", m_data, hold_data);
                hold_valid = m_valid && !m_ready;
                hold_data  = m_data;
                if (m_valid && m_ready) begin
                    if (rd_q.size() == 0) begin
                        chk(1'b0, "rd_unexpected", m_data, 64'd0);
                    end else begin
                        it = rd_q.pop_front();
                        chk({ri_e, ri_y, ri_x} == it.idx, "rd_index", {16'd0, ri_e, ri_y, ri_x}, {16'd0, it.idx});
                        chk(m_data == it.d, "rd_data", m_data, it.d);
                        if (it.last) fire_done = 1;
                    end
                end
                if (fire_done) done_stage = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 continuous valid, 1 alternate bubbles, 2 random bubbles
    task automatic do_load(input int mode, input bit rand_data, input bit both_start);
        logic [63:0] data [0:N-1];
        item_t it;
        int k = 0;
        int cyc = 0;
        for (int i = 0; i < N; i++) begin
            data[i]    = rand_data ? {$urandom, $urandom} : $realtobits(real'(i + 1));
            ref_mem[i] = data[i];
            it.idx = idx_of(i); it.d = data[i]; it.last = (i == N - 1);
            wr_q.push_back(it);
        end
        start_load = 1; start_dump = both_start;
        step();
        start_load = 0; start_dump = 0;
        @(negedge clk);
        chk(s_ready && !m_valid && busy, "enter_load", {61'd0, s_ready, m_valid, busy}, 64'd5);
        step();
        while (k < N && cyc < 200) begin
            s_valid    = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s_data     = s_valid ? data[k] : {$urandom, $urandom};
            start_dump = both_start && (k == 2);
            @(negedge clk);
            if (s_valid && s_ready) k++;
            cyc++;
            step();
        end
        s_valid = 0; start_dump = 0;
        if (cyc >= 200) chk(1'b0, "load_timeout", 64'(k), 64'(N));
        repeat (3) step();
        chk(wr_q.size() == 0 && !busy, "load_end", {32'(wr_q.size()), 31'd0, busy}, 64'd0);
        $display("load mode=%0d rand=%0d both=%0d cycles=%0d", mode, rand_data, both_start, cyc);
    endtask

    // mode: 0 continuous ready, 1 toggling 1,0,..., 2 random; stop_after>0 resets mid-dump
    task automatic do_dump(input int mode, input int stop_after);
        item_t it;
        int hs = 0;
        int cyc = 0;
        for (int i = 0; i < N; i++) begin
            it.idx = idx_of(i); it.d = ref_mem[i]; it.last = (i == N - 1);
            rd_q.push_back(it);
        end
        start_dump = 1;
        step();
        start_dump = 0;
        while (hs < N && cyc < 300) begin
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (m_valid && m_ready) hs++;
            cyc++;
            if (stop_after > 0 && hs == stop_after) break;
            step();
        end
        if (cyc >= 300) chk(1'b0, "dump_timeout", 64'(hs), 64'(N));
        step();
        m_ready = 0;
        if (stop_after > 0) begin
            rst = 1;
            @(posedge clk);
            @(negedge clk);
            chk(!busy && !m_valid && !done && !s_ready, "rst_mid_dump", {60'd0, busy, m_valid, done, s_ready}, 64'd0);
            chk({ri_e, ri_y, ri_x, wi_e} == 64'd0, "rst_indices", {ri_e, ri_y, ri_x, wi_e}, 64'd0);
            rd_q.delete();
            step();
            rst = 0;
            step();
        end else begin
            repeat (3) step();
            chk(rd_q.size() == 0 && !busy, "dump_end", {32'(rd_q.size()), 31'd0, busy}, 64'd0);
        end
        $display("dump mode=%0d stop_after=%0d handshakes=%0d cycles=%0d", mode, stop_after, hs, cyc);
    endtask

    initial begin : stimulus
        rst = 1; start_load = 0; start_dump = 0; s_valid = 0; m_ready = 0; s_data = '0;
        b_start_load = 0; b_start_dump = 0; b_s_valid = 0; b_m_ready = 0; b_s_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!busy && !done && !s_ready && !m_valid && !mem_write, "reset_state",
            {59'd0, busy, done, s_ready, m_valid, mem_write}, 64'd0);
        chk({wi_e, wi_y, wi_x, ri_e} == 64'd0 && ri_y == 0 && ri_x == 0, "reset_indices",
            {wi_e, wi_y, wi_x, ri_e}, 64'd0);
        step();
        rst = 0;
        step();

        do_load(0, 0, 0);   // 1.0..8.0, continuous
        do_dump(1, 0);      // toggling backpressure
        do_load(1, 1, 0);   // random data, alternate bubbles
        do_dump(2, 0);      // random backpressure
        do_load(2, 0, 1);   // both starts together, start_dump mid-load
        do_dump(0, 3);      // reset after 3 elements
        do_dump(0, 0);      // fresh dump restarts at (0,0,0) with 1.0

        // Single-element configuration
        b_start_load = 1;
        step();
        b_start_load = 0; b_s_valid = 1; b_s_data = $realtobits(5.0);
        @(negedge clk);
        chk(b_mem_write && b_s_ready, "n1_write", {62'd0, b_mem_write, b_s_ready}, 64'd3);
        chk({b_wi_e, b_wi_y, b_wi_x} == 48'd0, "n1_windex", {16'd0, b_wi_e, b_wi_y, b_wi_x}, 64'd0);
        chk(b_mem_in_data == $realtobits(5.0), "n1_wdata", b_mem_in_data, $realtobits(5.0));
        step();
        b_s_valid = 0;
        @(negedge clk);
        chk(b_done && !b_busy, "n1_load_done", {62'd0, b_done, b_busy}, 64'd2);
        step();
        @(negedge clk);
        chk(!b_done && !b_busy, "n1_idle", {62'd0, b_done, b_busy}, 64'd0);
        step();
        b_start_dump = 1;
        step();
        b_start_dump = 0; b_m_ready = 1;
        @(negedge clk);
        chk(b_m_valid && b_m_data == $realtobits(5.0), "n1_dump_data", b_m_data, $realtobits(5.0));
        step();
        b_m_ready = 0;
        @(negedge clk);
        chk(b_done && !b_m_valid, "n1_dump_done", {62'd0, b_done, b_m_valid}, 64'd2);
        $display("n1 config load/dump of 5.0 complete");
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/act_mem_ctrl.md
ACT_MEM_CTRL -- requirements
Module: act_mem_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 1, number of activation entries (feature maps).
REQ-002 SHALL have parameter DIM, default 1, spatial side length (DIM x DIM per entry).
REQ-003 SHALL have parameter DATA_SIZE, default 64, element width (IEEE double bit pattern).
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_load  input  1  request to fill memory from stream.
REQ-007 SHALL have port start_dump  input  1  request to stream memory contents out.
REQ-008 SHALL have port busy  output  1  high in LOAD or DUMP.
REQ-009 SHALL have port done  output  1  one-cycle pulse when an operation completes.
REQ-010 SHALL have ports s_valid input 1, s_ready output 1, s_data input DATA_SIZE  inbound element stream.
REQ-011 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_SIZE  outbound element stream.
REQ-012 SHALL have ports mem_write output 1, mem_in_data output DATA_SIZE, mem_index_entry/mem_index_y/mem_index_x output 16 each  memory write side.
REQ-013 SHALL have ports mem_read_index_entry/mem_read_index_y/mem_read_index_x output 16 each, mem_out_data input DATA_SIZE  memory read side (combinational read).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DUMP, DONE; reset state IDLE.
REQ-015 IDLE: start_load -> LOAD; else start_dump -> DUMP; both high same cycle -> LOAD (load priority); counters cleared on entry.
REQ-016 start_load/start_dump SHALL be ignored in LOAD, DUMP, DONE.
REQ-017 Element counter SHALL be raster order: x increments first, wraps DIM-1 -> 0 and increments y; y wraps DIM-1 -> 0 and increments entry; total N = ENTRY_NUM*DIM*DIM elements.
REQ-018 LOAD: s_ready = 1; mem_write = s_valid (combinational); mem_in_data = s_data; write indices = current counter; counter advances only on s_valid & s_ready.
REQ-019 LOAD: the transfer at counter (ENTRY_NUM-1, DIM-1, DIM-1) SHALL be the last; next state DONE, counter wraps to 0.
REQ-020 DUMP: m_valid = 1; read indices = current counter; m_data = mem_out_data (zero-cycle read latency); counter advances only on m_valid & m_ready; m_data SHALL hold stable while m_ready low.
REQ-021 DUMP: handshake at last index -> DONE.
REQ-022 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-023 Outside LOAD: s_ready = 0, mem_write = 0. Outside DUMP: m_valid = 0.
REQ-024 Write and read index outputs SHALL be zero-extended to 16 bits; in IDLE/DONE they SHALL be 0.
REQ-025 mem_in_data and m_data are pure pass-through; no arithmetic on data.
REQ-026 Throughput SHALL be one element per cycle with continuous valid/ready; LOAD of N elements completes (done high) on cycle N+1 after the first accepted transfer's cycle plus one DONE cycle.
REQ-027 DIM=1, ENTRY_NUM=1 (N=1) SHALL work: single transfer then DONE.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE, clear counters, and yield busy=0, done=0, s_ready=0, m_valid=0, mem_write=0, all indices 0, regardless of state (including mid-LOAD/DUMP).
REQ-029 No memory contents are cleared by this block; partial loads interrupted by reset remain in memory.

Structure
REQ-030 Shared package act_mem_pkg SHALL hold the state enum and INDEX_W = 16 constant.
REQ-031 Nested counter SHALL be sub-module act_index_counter (params ENTRY_NUM, DIM; inputs clk, rst, clear, advance; outputs entry/y/x, last).
REQ-032 Controller SHALL connect to the existing activation memory without glue logic.

Verification (ENTRY_NUM=2, DIM=2, N=8, memory model attached)
REQ-033 Load: start_load pulse, s_valid held high with data 1.0..8.0 -> writes at (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)...(1,1,1); done pulses once after 8th transfer; busy low afterward.
REQ-034 Backpressure on dump: after load, start_dump, m_ready toggling 1,0,1,0 -> m_data sequence 1.0..8.0 with no loss or duplication; m_data stable during m_ready=0.
REQ-035 Bubbles on load: s_valid low on alternate cycles -> exactly 8 writes, indices skip nothing, mem_write never high while s_valid low.
REQ-036 Simultaneous start_load and start_dump in IDLE -> LOAD entered; start_dump asserted mid-LOAD ignored.
REQ-037 Reset mid-DUMP after 3 elements -> next cycle IDLE, m_valid=0, indices 0; fresh start_dump restarts at (0,0,0) with 1.0.
REQ-038 N=1 config (ENTRY_NUM=1, DIM=1): single load transfer of 5.0 -> write at (0,0,0), done next cycle; dump returns 5.0.
